// File: rtl/dispatch_buffer.sv
// Bundle FIFO between rename/dispatch and the issue queue.
// Waiting operands are woken by the writeback snoop, both while a bundle is stored and in the cycle it leaves.
package parameters;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int DISPATCH_ADDR_WIDTH  = 2;
    localparam int ROB_ADDR_WIDTH       = 5;
endpackage

package common;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_cmd_t;
    typedef enum logic {OP_REG, OP_IMM} op_type_t;
endpackage

module dispatch_buffer
    import parameters::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_en              [0:DISPATCH_WIDTH-1],
    input  common::alu_cmd_t                in_alu_cmd         [0:DISPATCH_WIDTH-1],
    input  logic                            in_op1_valid       [0:DISPATCH_WIDTH-1],
    input  logic                            in_op2_valid       [0:DISPATCH_WIDTH-1],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] in_op1             [0:DISPATCH_WIDTH-1],
    input  logic [31:0]                     in_op2             [0:DISPATCH_WIDTH-1],
    input  common::op_type_t                in_op2_type        [0:DISPATCH_WIDTH-1],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] in_phys_rd         [0:DISPATCH_WIDTH-1],
    input  logic [DISPATCH_ADDR_WIDTH-1:0]  in_bank_addr       [0:DISPATCH_WIDTH-1],
    input  logic [ROB_ADDR_WIDTH-1:0]       in_rob_addr        [0:DISPATCH_WIDTH-1],
    input  logic                            wb_valid           [0:DISPATCH_WIDTH-1],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd         [0:DISPATCH_WIDTH-1],
    input  logic                            isq_full,
    output logic                            dispatch_en        [0:DISPATCH_WIDTH-1],
    output common::alu_cmd_t                dispatch_alu_cmd   [0:DISPATCH_WIDTH-1],
    output logic                            dispatch_op1_valid [0:DISPATCH_WIDTH-1],
    output logic                            dispatch_op2_valid [0:DISPATCH_WIDTH-1],
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] dispatch_op1       [0:DISPATCH_WIDTH-1],
    output logic [31:0]                     dispatch_op2       [0:DISPATCH_WIDTH-1],
    output common::op_type_t                dispatch_op2_type  [0:DISPATCH_WIDTH-1],
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] dispatch_phys_rd   [0:DISPATCH_WIDTH-1],
    output logic [DISPATCH_ADDR_WIDTH-1:0]  dispatch_bank_addr [0:DISPATCH_WIDTH-1],
    output logic [ROB_ADDR_WIDTH-1:0]       dispatch_rob_addr  [0:DISPATCH_WIDTH-1]
);

    localparam int PW  = $clog2(BUF_DEPTH);
    localparam int CW  = PW + 1;
    localparam int PRW = PHYS_REGS_ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

    typedef struct packed {
        logic                          en;
        common::alu_cmd_t              alu_cmd;
        logic                          op1_valid;
        logic                          op2_valid;
        logic [PRW-1:0]                op1;
        logic [31:0]                   op2;
        common::op_type_t              op2_type;
        logic [PRW-1:0]                phys_rd;
        logic [DISPATCH_ADDR_WIDTH-1:0] bank_addr;
        logic [ROB_ADDR_WIDTH-1:0]     rob_addr;
    } lane_t;

    lane_t          entries_q [BUF_DEPTH][DISPATCH_WIDTH];
    lane_t          entries_d [BUF_DEPTH][DISPATCH_WIDTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic                               pushEn;
    logic                               popEn;
    logic [DISPATCH_WIDTH-1:0]          wbValidVec;
    logic [DISPATCH_WIDTH-1:0][PRW-1:0] wbRdVec;

    function automatic logic wbHit(input logic [PRW-1:0] addr,
                                   input logic [DISPATCH_WIDTH-1:0] vld,
                                   input logic [DISPATCH_WIDTH-1:0][PRW-1:0] rd);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            if (vld[w] && rd[w] == addr) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        wbValidVec = '0;
        wbRdVec    = '0;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            wbValidVec[w] = wb_valid[w];
            wbRdVec[w]    = wb_phys_rd[w];
        end
    end

    // in_ready depends only on stored occupancy, so a pop never frees a slot in the same cycle
    assign in_ready = (count_q < DEPTH_CNT);
    assign pushEn   = in_valid && in_ready;
    assign popEn    = (count_q != '0) && !isq_full;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        for (int i = 0; i < BUF_DEPTH; i++) begin
            for (int b = 0; b < DISPATCH_WIDTH; b++) begin
                if (!entries_q[i][b].op1_valid && wbHit(entries_q[i][b].op1, wbValidVec, wbRdVec)) begin
                    entries_d[i][b].op1_valid = 1'b1;
                end
                if (!entries_q[i][b].op2_valid && wbHit(entries_q[i][b].op2[PRW-1:0], wbValidVec, wbRdVec)) begin
                    entries_d[i][b].op2_valid = 1'b1;
                end
            end
        end

        if (pushEn) begin
            for (int b = 0; b < DISPATCH_WIDTH; b++) begin
                entries_d[tail_q][b].en        = in_en[b];
                entries_d[tail_q][b].alu_cmd   = in_alu_cmd[b];
                entries_d[tail_q][b].op1_valid = in_op1_valid[b] | wbHit(in_op1[b], wbValidVec, wbRdVec);
                entries_d[tail_q][b].op2_valid = in_op2_valid[b] | wbHit(in_op2[b][PRW-1:0], wbValidVec, wbRdVec);
                entries_d[tail_q][b].op1       = in_op1[b];
                entries_d[tail_q][b].op2       = in_op2[b];
                entries_d[tail_q][b].op2_type  = in_op2_type[b];
                entries_d[tail_q][b].phys_rd   = in_phys_rd[b];
                entries_d[tail_q][b].bank_addr = in_bank_addr[b];
                entries_d[tail_q][b].rob_addr  = in_rob_addr[b];
            end
            tail_d = tail_q + 1'b1;
        end

        if (popEn) begin
            head_d = head_q + 1'b1;
        end

        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: nothing is presented as valid until count is non-zero
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    always_comb begin
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            dispatch_en[b]        = entries_q[head_q][b].en && popEn;
            dispatch_alu_cmd[b]   = entries_q[head_q][b].alu_cmd;
            dispatch_op1_valid[b] = entries_q[head_q][b].op1_valid
                                  | wbHit(entries_q[head_q][b].op1, wbValidVec, wbRdVec);
            dispatch_op2_valid[b] = entries_q[head_q][b].op2_valid
                                  | wbHit(entries_q[head_q][b].op2[PRW-1:0], wbValidVec, wbRdVec);
            dispatch_op1[b]       = entries_q[head_q][b].op1;
            dispatch_op2[b]       = entries_q[head_q][b].op2;
            dispatch_op2_type[b]  = entries_q[head_q][b].op2_type;
            dispatch_phys_rd[b]   = entries_q[head_q][b].phys_rd;
            dispatch_bank_addr[b] = entries_q[head_q][b].bank_addr;
            dispatch_rob_addr[b]  = entries_q[head_q][b].rob_addr;
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: a queue-of-bundles model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dispatch_buffer;
    import parameters::*;

    localparam int W     = DISPATCH_WIDTH;
    localparam int PRW   = PHYS_REGS_ADDR_WIDTH;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, isq_full;
    logic                           in_en        [0:W-1];
    common::alu_cmd_t               in_alu_cmd   [0:W-1];
    logic                           in_op1_valid [0:W-1];
    logic                           in_op2_valid [0:W-1];
    logic [PRW-1:0]                 in_op1       [0:W-1];
    logic [31:0]                    in_op2       [0:W-1];
    common::op_type_t               in_op2_type  [0:W-1];
    logic [PRW-1:0]                 in_phys_rd   [0:W-1];
    logic [DISPATCH_ADDR_WIDTH-1:0] in_bank_addr [0:W-1];
    logic [ROB_ADDR_WIDTH-1:0]      in_rob_addr  [0:W-1];
    logic                           wb_valid     [0:W-1];
    logic [PRW-1:0]                 wb_phys_rd   [0:W-1];
    logic                           dispatch_en        [0:W-1];
    common::alu_cmd_t               dispatch_alu_cmd   [0:W-1];
    logic                           dispatch_op1_valid [0:W-1];
    logic                           dispatch_op2_valid [0:W-1];
    logic [PRW-1:0]                 dispatch_op1       [0:W-1];
    logic [31:0]                    dispatch_op2       [0:W-1];
    common::op_type_t               dispatch_op2_type  [0:W-1];
    logic [PRW-1:0]                 dispatch_phys_rd   [0:W-1];
    logic [DISPATCH_ADDR_WIDTH-1:0] dispatch_bank_addr [0:W-1];
    logic [ROB_ADDR_WIDTH-1:0]      dispatch_rob_addr  [0:W-1];

    dispatch_buffer #(.BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_en(in_en), .in_alu_cmd(in_alu_cmd), .in_op1_valid(in_op1_valid),
        .in_op2_valid(in_op2_valid), .in_op1(in_op1), .in_op2(in_op2),
        .in_op2_type(in_op2_type), .in_phys_rd(in_phys_rd), .in_bank_addr(in_bank_addr),
        .in_rob_addr(in_rob_addr), .wb_valid(wb_valid), .wb_phys_rd(wb_phys_rd),
        .isq_full(isq_full), .dispatch_en(dispatch_en), .dispatch_alu_cmd(dispatch_alu_cmd),
        .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op2_valid(dispatch_op2_valid),
        .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
        .dispatch_op2_type(dispatch_op2_type), .dispatch_phys_rd(dispatch_phys_rd),
        .dispatch_bank_addr(dispatch_bank_addr), .dispatch_rob_addr(dispatch_rob_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                           en;
        logic [3:0]                     alu;
        logic                           op1v;
        logic                           op2v;
        logic [PRW-1:0]                 op1;
        logic [31:0]                    op2;
        logic                           imm;
        logic [PRW-1:0]                 rd;
        logic [DISPATCH_ADDR_WIDTH-1:0] bank;
        logic [ROB_ADDR_WIDTH-1:0]      rob;
    } slot_t;
    typedef slot_t [W-1:0] bundle_t;

    bundle_t model[$];
    int      seen[$];
    logic    recordOn = 1'b0;
    int      checks   = 0;
    int      fails    = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic snoop(input logic [PRW-1:0] r);
        for (int w = 0; w < W; w++) begin
            if (wb_valid[w] && wb_phys_rd[w] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic slot_t mkSlot(input logic en, input int rob, input int op1, input logic op1v,
                                     input int op2, input logic op2v);
        slot_t s;
        s.en   = en;
        s.alu  = 4'(rob % 8);
        s.op1v = op1v;
        s.op2v = op2v;
        s.op1  = PRW'(op1);
        s.op2  = 32'(op2);
        s.imm  = 1'b0;
        s.rd   = PRW'(rob + 1);
        s.bank = DISPATCH_ADDR_WIDTH'(rob);
        s.rob  = ROB_ADDR_WIDTH'(rob);
        return s;
    endfunction

    function automatic bundle_t mkBundle(input int r);
        bundle_t bun;
        bun[0] = mkSlot(1'b1, r, r % 8, 1'b1, 40 + r, 1'b1);
        bun[1] = mkSlot(1'b1, r + 1, (r + 3) % 8, 1'b1, 100 + r, 1'b1);
        bun[1].imm = 1'b1;
        return bun;
    endfunction

    function automatic bundle_t inputBundle();
        bundle_t bun;
        for (int b = 0; b < W; b++) begin
            bun[b].en   = in_en[b];
            bun[b].alu  = in_alu_cmd[b];
            bun[b].op1v = in_op1_valid[b] | snoop(in_op1[b]);
            bun[b].op2v = in_op2_valid[b] | snoop(in_op2[b][PRW-1:0]);
            bun[b].op1  = in_op1[b];
            bun[b].op2  = in_op2[b];
            bun[b].imm  = (in_op2_type[b] == common::OP_IMM);
            bun[b].rd   = in_phys_rd[b];
            bun[b].bank = in_bank_addr[b];
            bun[b].rob  = in_rob_addr[b];
        end
        return bun;
    endfunction

    // Reference model: a plain queue of bundles updated at each edge
    initial forever begin
        logic    doPop, doPush;
        bundle_t t;
        @(posedge clk or posedge rst);
        if (rst || flush) begin
            model.delete();
        end else begin
            doPop  = (model.size() != 0) && !isq_full;
            doPush = in_valid && (model.size() < DEPTH);
            for (int i = 0; i < model.size(); i++) begin
                t = model[i];
                for (int b = 0; b < W; b++) begin
                    t[b].op1v = t[b].op1v | snoop(t[b].op1);
                    t[b].op2v = t[b].op2v | snoop(t[b].op2[PRW-1:0]);
                end
                model[i] = t;
            end
            if (doPop) void'(model.pop_front());
            if (doPush) model.push_back(inputBundle());
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        bundle_t hd;
        slot_t   e, g;
        logic    expEn;
        @(negedge clk);
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, model.size() < DEPTH});
        for (int b = 0; b < W; b++) begin
            expEn = (model.size() != 0) && !isq_full;
            if (model.size() != 0) begin
                hd    = model[0];
                expEn = expEn && hd[b].en;
            end
            checkOutput("dispatch_en", {63'd0, dispatch_en[b]}, {63'd0, expEn});
            if (model.size() != 0) begin
                e      = hd[b];
                e.en   = expEn;
                e.op1v = e.op1v | snoop(e.op1);
                e.op2v = e.op2v | snoop(e.op2[PRW-1:0]);
                g.en   = dispatch_en[b];
                g.alu  = dispatch_alu_cmd[b];
                g.op1v = dispatch_op1_valid[b];
                g.op2v = dispatch_op2_valid[b];
                g.op1  = dispatch_op1[b];
                g.op2  = dispatch_op2[b];
                g.imm  = (dispatch_op2_type[b] == common::OP_IMM);
                g.rd   = dispatch_phys_rd[b];
                g.bank = dispatch_bank_addr[b];
                g.rob  = dispatch_rob_addr[b];
                checkOutput("head_lane", {5'd0, g}, {5'd0, e});
            end
        end
        if (recordOn && dispatch_en[0]) seen.push_back(int'(dispatch_rob_addr[0]));
    end

    task automatic applyStimulus(input logic valid, input bundle_t bun);
        in_valid = valid;
        for (int b = 0; b < W; b++) begin
            in_en[b]        = bun[b].en;
            in_alu_cmd[b]   = common::alu_cmd_t'(bun[b].alu);
            in_op1_valid[b] = bun[b].op1v;
            in_op2_valid[b] = bun[b].op2v;
            in_op1[b]       = bun[b].op1;
            in_op2[b]       = bun[b].op2;
            in_op2_type[b]  = bun[b].imm ? common::OP_IMM : common::OP_REG;
            in_phys_rd[b]   = bun[b].rd;
            in_bank_addr[b] = bun[b].bank;
            in_rob_addr[b]  = bun[b].rob;
        end
    endtask

    task automatic setWb(input int lane, input logic v, input int r);
        wb_valid[lane]   = v;
        wb_phys_rd[lane] = PRW'(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bundle_t idle, bun;
        int      k, cyc;
        logic    accept;

        idle = '0;
        rst = 1'b1;
        flush = 1'b0;
        isq_full = 1'b0;
        for (int w = 0; w < W; w++) setWb(w, 1'b0, 0);
        applyStimulus(1'b0, idle);
        #12;
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_en0", {63'd0, dispatch_en[0]}, 64'd0);
        checkOutput("reset_en1", {63'd0, dispatch_en[1]}, 64'd0);
        rst = 1'b0;
        step();

        // Single bundle, lane 1 empty
        bun[0] = mkSlot(1'b1, 3, 1, 1'b1, 2, 1'b1);
        bun[1] = mkSlot(1'b0, 4, 1, 1'b1, 2, 1'b1);
        applyStimulus(1'b1, bun);
        step();
        applyStimulus(1'b0, idle);
        @(negedge clk);
        checkOutput("single_en0", {63'd0, dispatch_en[0]}, 64'd1);
        checkOutput("single_en1", {63'd0, dispatch_en[1]}, 64'd0);
        checkOutput("single_rob0", {59'd0, dispatch_rob_addr[0]}, 64'd3);
        step();
        @(negedge clk);
        checkOutput("single_drained_en0", {63'd0, dispatch_en[0]}, 64'd0);
        checkOutput("single_drained_en1", {63'd0, dispatch_en[1]}, 64'd0);
        step();

        // Fill while stalled, then drain in order
        isq_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, mkBundle(10 + i));
            step();
        end
        applyStimulus(1'b0, idle);
        @(negedge clk);
        checkOutput("full_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("full_en0", {63'd0, dispatch_en[0]}, 64'd0);
        step();
        isq_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("drain_rob0", {59'd0, dispatch_rob_addr[0]}, 64'(10 + i));
            checkOutput("drain_en0", {63'd0, dispatch_en[0]}, 64'd1);
            if (i == 0) checkOutput("drain_ready_first", {63'd0, in_ready}, 64'd0);
            if (i == 1) checkOutput("drain_ready_second", {63'd0, in_ready}, 64'd1);
            step();
        end

        // Wakeup while stalled
        isq_full = 1'b1;
        bun[0] = mkSlot(1'b1, 5, 17, 1'b0, 3, 1'b1);
        bun[1] = mkSlot(1'b1, 6, 2, 1'b1, 17, 1'b1);
        applyStimulus(1'b1, bun);
        step();
        applyStimulus(1'b0, idle);
        @(negedge clk);
        checkOutput("wake_before", {63'd0, dispatch_op1_valid[0]}, 64'd0);
        step();
        setWb(1, 1'b1, 17);
        step();
        setWb(1, 1'b0, 0);
        @(negedge clk);
        checkOutput("wake_stored", {63'd0, dispatch_op1_valid[0]}, 64'd1);
        step();
        isq_full = 1'b0;
        @(negedge clk);
        checkOutput("wake_release_en", {63'd0, dispatch_en[0]}, 64'd1);
        checkOutput("wake_release_op1v", {63'd0, dispatch_op1_valid[0]}, 64'd1);
        checkOutput("wake_other_op2v", {63'd0, dispatch_op2_valid[1]}, 64'd1);
        step();

        // Same-cycle wakeup on push, then on output
        isq_full = 1'b1;
        bun[0] = mkSlot(1'b1, 7, 1, 1'b1, 9, 1'b0);
        bun[1] = mkSlot(1'b0, 0, 1, 1'b1, 1, 1'b1);
        applyStimulus(1'b1, bun);
        setWb(0, 1'b1, 9);
        step();
        setWb(0, 1'b0, 0);
        applyStimulus(1'b0, idle);
        @(negedge clk);
        checkOutput("push_wake_op2v", {63'd0, dispatch_op2_valid[0]}, 64'd1);
        step();
        bun[0] = mkSlot(1'b1, 8, 5, 1'b0, 1, 1'b1);
        applyStimulus(1'b1, bun);
        step();
        applyStimulus(1'b0, idle);
        isq_full = 1'b0;
        @(negedge clk);
        checkOutput("pop_wake_first_rob", {59'd0, dispatch_rob_addr[0]}, 64'd7);
        step();
        setWb(0, 1'b1, 5);
        @(negedge clk);
        checkOutput("pop_wake_rob", {59'd0, dispatch_rob_addr[0]}, 64'd8);
        checkOutput("pop_wake_en", {63'd0, dispatch_en[0]}, 64'd1);
        checkOutput("pop_wake_op1v", {63'd0, dispatch_op1_valid[0]}, 64'd1);
        step();
        setWb(0, 1'b0, 0);

        // Wrap-around with isq_full toggling every cycle
        recordOn = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 100) begin
            applyStimulus(1'b1, mkBundle(20 + k));
            isq_full = cyc[0];
            accept = in_ready;
            step();
            if (accept) k++;
            cyc++;
        end
        applyStimulus(1'b0, idle);
        isq_full = 1'b0;
        repeat (6) step();
        recordOn = 1'b0;
        checkOutput("wrap_all_pushed", 64'(k), 64'd10);
        checkOutput("wrap_pop_count", 64'(seen.size()), 64'd10);
        for (int i = 0; i < seen.size() && i < 10; i++) begin
            checkOutput("wrap_order", 64'(seen[i]), 64'(20 + i));
        end

        // Flush during simultaneous push and pop with three entries held
        isq_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkBundle(1 + i));
            step();
        end
        applyStimulus(1'b1, mkBundle(9));
        isq_full = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_pre_en0", {63'd0, dispatch_en[0]}, 64'd1);
        step();
        flush = 1'b0;
        applyStimulus(1'b0, idle);
        @(negedge clk);
        checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("flush_en0", {63'd0, dispatch_en[0]}, 64'd0);
        checkOutput("flush_en1", {63'd0, dispatch_en[1]}, 64'd0);
        step();
        @(negedge clk);
        checkOutput("flush_later_en0", {63'd0, dispatch_en[0]}, 64'd0);
        step();

        // Asynchronous reset mid-stream
        isq_full = 1'b1;
        applyStimulus(1'b1, mkBundle(12));
        step();
        applyStimulus(1'b1, mkBundle(14));
        step();
        applyStimulus(1'b0, idle);
        isq_full = 1'b0;
        #2;
        checkOutput("prereset_en0", {63'd0, dispatch_en[0]}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_en0", {63'd0, dispatch_en[0]}, 64'd0);
        checkOutput("async_rst_en1", {63'd0, dispatch_en[1]}, 64'd0);
        checkOutput("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        #3;
        rst = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
